// File: rtl/cpu_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_mem_pkg
// Brief  : Shared widths, sizes and types for the 6502 system memory model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_mem_pkg;

   localparam int REG_WIDTH  = 8;
   localparam int ADDR_WIDTH = 16;
   localparam int MEM_DEPTH  = 256;

   // Reset vector target where firmware images are expected to start.
   localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;

   typedef logic [REG_WIDTH-1:0] reg_t;

endpackage

`default_nettype wire

// File: rtl/cpu_mem.sv
//------------------------------------------------------------------------------
// Module : cpu_mem
// Brief  : Byte-wide single-port RAM with whole-array preload and flat monitor.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_mem
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       we,
   input  logic [REG_WIDTH-1:0]       din,
   input  logic [ADDR_WIDTH-1:0]      addr,
   output logic [REG_WIDTH-1:0]       dout,
   input  logic                       override_mem,
   input  logic [DEPTH*REG_WIDTH-1:0] mem_override_in,
   output logic [DEPTH*REG_WIDTH-1:0] mem_monitor
);

   localparam int                    c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH+1)'(DEPTH);

   reg_t              r_mem [DEPTH];
   reg_t              w_image [DEPTH];
   logic              w_in_range;
   logic [c_idx_w-1:0] w_idx;

   // Compare one bit wider so DEPTH = 2^ADDR_WIDTH stays representable.
   assign w_in_range = ({1'b0, addr} < c_depth);
   assign w_idx      = addr[c_idx_w-1:0];

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
         assign w_image[i] = mem_override_in[i*REG_WIDTH +: REG_WIDTH];
      end
      for (genvar i = 0; i < DEPTH; i++) begin : g_monitor
         assign mem_monitor[i*REG_WIDTH +: REG_WIDTH] = r_mem[i];
      end
   endgenerate

   // Array has no reset: preload must work while reset_n is still low.
   always_ff @(posedge clk) begin
      if (override_mem) begin
         r_mem <= w_image;
      end else if (reset_n && we && w_in_range) begin
         r_mem[w_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout <= '0;
      end else if (!w_in_range) begin
         dout <= '0;
      end else if (override_mem) begin
         dout <= w_image[w_idx];
      end else if (we) begin
         dout <= din;
      end else begin
         dout <= r_mem[w_idx];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem.sv
//------------------------------------------------------------------------------
// Module : tb_cpu_mem
// Brief  : Directed self-checking bench for cpu_mem.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_mem;
   import cpu_mem_pkg::*;

   localparam int DEPTH = 256;
   localparam int W     = 8;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 we;
   logic [W-1:0]         din;
   logic [15:0]          addr;
   logic [W-1:0]         dout;
   logic                 override_mem;
   logic [DEPTH*W-1:0]   mem_override_in;
   logic [DEPTH*W-1:0]   mem_monitor;

   int tests_run    = 0;
   int tests_failed = 0;

   cpu_mem #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .we              (we),
      .din             (din),
      .addr            (addr),
      .dout            (dout),
      .override_mem    (override_mem),
      .mem_override_in (mem_override_in),
      .mem_monitor     (mem_monitor)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n      = 1'b0;
      override_mem = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_override_in[i*W +: W] = 8'(i) ^ 8'hA5;
      #1;
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_dout: got %h expected 00", dout);
      end
      tick();
      tests_run++;
      if (mem_monitor[0 +: W] !== 8'hA5) begin
         tests_failed++;
         $display("FAIL preload_byte0: got %h expected a5", mem_monitor[0 +: W]);
      end
      tests_run++;
      if (mem_monitor[255*W +: W] !== 8'h5A) begin
         tests_failed++;
         $display("FAIL preload_byte255: got %h expected 5a", mem_monitor[255*W +: W]);
      end
      tests_run++;
      if (mem_monitor[16*W +: W] !== 8'hB5) begin
         tests_failed++;
         $display("FAIL preload_byte16: got %h expected b5", mem_monitor[16*W +: W]);
      end
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_dout_after_override: got %h expected 00", dout);
      end
      @(negedge clk);
      override_mem = 1'b0;
      we           = 1'b1;
      addr         = 16'h0030;
      din          = 8'hCC;
      tick();
      tests_run++;
      if (mem_monitor[48*W +: W] !== 8'h95) begin
         tests_failed++;
         $display("FAIL write_in_reset: got %h expected 95", mem_monitor[48*W +: W]);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      reset_n = 1'b1;
      we      = 1'b1;
      addr    = 16'h0010;
      din     = 8'h3C;
      tick();
      tests_run++;
      if (mem_monitor[16*W +: W] !== 8'h3C) begin
         tests_failed++;
         $display("FAIL write_monitor: got %h expected 3c", mem_monitor[16*W +: W]);
      end
      @(negedge clk);
      we   = 1'b0;
      addr = 16'h0011;
      tick();
      tests_run++;
      if (dout !== 8'hB4) begin
         tests_failed++;
         $display("FAIL read_preload: got %h expected b4", dout);
      end
      @(negedge clk);
      addr = 16'h0010;
      tick();
      tests_run++;
      if (dout !== 8'h3C) begin
         tests_failed++;
         $display("FAIL read_written: got %h expected 3c", dout);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL async_reset_dout: got %h expected 00", dout);
      end
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      addr    = 16'h0010;
      tick();
      tests_run++;
      if (dout !== 8'h3C) begin
         tests_failed++;
         $display("FAIL retain_after_reset: got %h expected 3c", dout);
      end
   endtask

   task automatic test_read_during_write();
      @(negedge clk);
      we   = 1'b1;
      addr = 16'h0020;
      din  = 8'h77;
      tick();
      tests_run++;
      if (dout !== 8'h77) begin
         tests_failed++;
         $display("FAIL rdw_dout: got %h expected 77", dout);
      end
      tests_run++;
      if (mem_monitor[32*W +: W] !== 8'h77) begin
         tests_failed++;
         $display("FAIL rdw_array: got %h expected 77", mem_monitor[32*W +: W]);
      end
   endtask

   task automatic test_override_priority();
      @(negedge clk);
      override_mem = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_override_in[i*W +: W] = 8'h11;
      we   = 1'b1;
      addr = 16'h0005;
      din  = 8'hFF;
      tick();
      tests_run++;
      if (mem_monitor[5*W +: W] !== 8'h11) begin
         tests_failed++;
         $display("FAIL override_loc5: got %h expected 11", mem_monitor[5*W +: W]);
      end
      tests_run++;
      if (dout !== 8'h11) begin
         tests_failed++;
         $display("FAIL override_dout: got %h expected 11", dout);
      end
      tests_run++;
      if (mem_monitor[32*W +: W] !== 8'h11) begin
         tests_failed++;
         $display("FAIL override_loc32: got %h expected 11", mem_monitor[32*W +: W]);
      end
      @(negedge clk);
      override_mem = 1'b0;
      we           = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [DEPTH*W-1:0] snap;
      @(negedge clk);
      snap = mem_monitor;
      we   = 1'b1;
      addr = 16'h0100;
      din  = 8'hEE;
      tick();
      tests_run++;
      if (mem_monitor !== snap) begin
         tests_failed++;
         $display("FAIL oor_write_monitor: byte0 got %h expected 11", mem_monitor[0 +: W]);
      end
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL oor_write_dout: got %h expected 00", dout);
      end
      @(negedge clk);
      we = 1'b0;
      tick();
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL oor_read: got %h expected 00", dout);
      end
      @(negedge clk);
      addr = 16'h0000;
      tick();
      tests_run++;
      if (dout !== 8'h11) begin
         tests_failed++;
         $display("FAIL oor_no_alias: got %h expected 11", dout);
      end
      @(negedge clk);
      we   = 1'b1;
      addr = 16'h00FF;
      din  = 8'h42;
      tick();
      tests_run++;
      if (mem_monitor[255*W +: W] !== 8'h42) begin
         tests_failed++;
         $display("FAIL last_loc_write: got %h expected 42", mem_monitor[255*W +: W]);
      end
      @(negedge clk);
      we   = 1'b0;
      addr = 16'hFFFF;
      tick();
      tests_run++;
      if (dout !== 8'h00) begin
         tests_failed++;
         $display("FAIL oor_top_read: got %h expected 00", dout);
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      we              = 1'b0;
      din             = '0;
      addr            = '0;
      override_mem    = 1'b0;
      mem_override_in = '0;
      test_reset();
      test_write_read();
      test_async_reset();
      test_read_during_write();
      test_override_priority();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
